// File: rtl/debug_frame_sender.sv
// OCD debug-frame initiator: latches one command, sends the 10-byte frame
// (5A A5 op addr data checksum) as 8N1 UART on TXD, then returns to idle.
`ifndef UART_BAUD_PERIOD
`define UART_BAUD_PERIOD 4
`endif

// state | meaning
// IDLE  | waiting for a command, TXD high
// START | start bit of byte byte_idx
// DATA  | data bit bit_cnt of byte byte_idx, LSB first
// STOP  | stop bit of byte byte_idx
// DONE  | frame complete; one cycle, behaves as IDLE (accepts a command)
module debug_frame_sender #(
  parameter int BAUD_PERIOD = `UART_BAUD_PERIOD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        abort,
  output logic        TXD,
  output logic        busy,
  output logic        frame_done
);

  localparam int BW = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_PERIOD - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [3:0]    byte_idx, byte_nxt;
  logic [7:0]    opcode_q;
  logic [15:0]   addr_q;
  logic [31:0]   data_q;
  logic          txd_q, txd_nxt;
  logic          accept, baud_last;
  logic [7:0]    sum, tx_byte;

  assign cmd_ready  = (state == S_IDLE) || (state == S_DONE);
  assign busy       = ~cmd_ready;
  assign frame_done = (state == S_DONE);
  assign TXD        = txd_q;
  assign accept     = cmd_valid & cmd_ready;
  assign baud_last  = (baud_cnt == BAUD_LAST);

  assign sum = opcode_q + addr_q[15:8] + addr_q[7:0] + data_q[31:24]
             + data_q[23:16] + data_q[15:8] + data_q[7:0];

  // byte selected by the index the line will carry next cycle
  always_comb begin
    tx_byte = 8'h00;
    case (byte_nxt)
      4'd0:    tx_byte = 8'h5A;
      4'd1:    tx_byte = 8'hA5;
      4'd2:    tx_byte = opcode_q;
      4'd3:    tx_byte = addr_q[15:8];
      4'd4:    tx_byte = addr_q[7:0];
      4'd5:    tx_byte = data_q[31:24];
      4'd6:    tx_byte = data_q[23:16];
      4'd7:    tx_byte = data_q[15:8];
      4'd8:    tx_byte = data_q[7:0];
      4'd9:    tx_byte = 8'h00 - sum;
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    byte_nxt  = byte_idx;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = accept ? S_START : S_IDLE;
        baud_nxt  = '0;
        bit_nxt   = '0;
        byte_nxt  = '0;
      end
      S_START: begin
        baud_nxt = baud_cnt + BW'(1);
        if (baud_last) begin
          state_nxt = S_DATA;
          baud_nxt  = '0;
          bit_nxt   = '0;
        end
      end
      S_DATA: begin
        baud_nxt = baud_cnt + BW'(1);
        if (baud_last) begin
          baud_nxt = '0;
          if (bit_cnt == 3'd7) state_nxt = S_STOP;
          else                 bit_nxt   = bit_cnt + 3'd1;
        end
      end
      S_STOP: begin
        baud_nxt = baud_cnt + BW'(1);
        if (baud_last) begin
          baud_nxt = '0;
          if (byte_idx == 4'd9) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_START;
            byte_nxt  = byte_idx + 4'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE) && (state != S_DONE)) begin
      state_nxt = S_IDLE;
      baud_nxt  = '0;
      bit_nxt   = '0;
      byte_nxt  = '0;
    end
  end

  always_comb begin
    txd_nxt = 1'b1;
    case (state_nxt)
      S_START: txd_nxt = 1'b0;
      S_DATA:  txd_nxt = tx_byte[bit_nxt];
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      txd_q    <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      byte_idx <= byte_nxt;
      txd_q    <= txd_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opcode_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else if (accept) begin
      opcode_q <= cmd_opcode;
      addr_q   <= cmd_addr;
      data_q   <= cmd_data;
    end
  end

endmodule

// File: tb/tb_debug_frame_sender.sv
// Bench for debug_frame_sender: two instances (BAUD_PERIOD 4 and 2) checked
// cycle by cycle against an expected serial stream built from the frame rules.
module tb_debug_frame_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, valid4, valid2, abort;
  logic [7:0]  opcode;
  logic [15:0] addr;
  logic [31:0] data;
  logic ready4, busy4, done4, txd4;
  logic ready2, busy2, done2, txd2;

  debug_frame_sender #(.BAUD_PERIOD(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(valid4), .cmd_ready(ready4),
    .cmd_opcode(opcode), .cmd_addr(addr), .cmd_data(data), .abort(abort),
    .TXD(txd4), .busy(busy4), .frame_done(done4));

  debug_frame_sender #(.BAUD_PERIOD(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(valid2), .cmd_ready(ready2),
    .cmd_opcode(opcode), .cmd_addr(addr), .cmd_data(data), .abort(abort),
    .TXD(txd2), .busy(busy2), .frame_done(done2));

  int cur_sel = 0;
  int total = 0;
  int bad = 0;
  logic txd_m, ready_m, busy_m, done_m;

  always_comb begin
    txd_m   = (cur_sel != 0) ? txd2   : txd4;
    ready_m = (cur_sel != 0) ? ready2 : ready4;
    busy_m  = (cur_sel != 0) ? busy2  : busy4;
    done_m  = (cur_sel != 0) ? done2  : done4;
  end

  logic [7:0] exp_b[10];
  logic [7:0] rx_b[10];
  logic [7:0] basic_lit[10];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int bpc();
    return (cur_sel != 0) ? 2 : 4;
  endfunction

  task automatic model(input logic [7:0] op, input logic [15:0] a, input logic [31:0] d);
    int s;
    exp_b[0] = 8'h5A;
    exp_b[1] = 8'hA5;
    exp_b[2] = op;
    exp_b[3] = a[15:8];
    exp_b[4] = a[7:0];
    exp_b[5] = d[31:24];
    exp_b[6] = d[23:16];
    exp_b[7] = d[15:8];
    exp_b[8] = d[7:0];
    s = 0;
    for (int i = 2; i <= 8; i++) s += int'(exp_b[i]);
    exp_b[9] = 8'((256 - (s % 256)) % 256);
  endtask

  task automatic set_valid(input logic v);
    if (cur_sel != 0) valid2 = v;
    else              valid4 = v;
  endtask

  task automatic set_cmd(input logic [7:0] op, input logic [15:0] a, input logic [31:0] d);
    opcode = op;
    addr   = a;
    data   = d;
  endtask

  // returns just after the accepting posedge
  task automatic accept(input logic [7:0] op, input logic [15:0] a, input logic [31:0] d,
                        input logic ab);
    @(negedge clk);
    set_cmd(op, a, d);
    abort = ab;
    set_valid(1'b1);
    for (int i = 0; i < 300 && ready_m !== 1'b1; i++) @(negedge clk);
    chk("ready_wait", 32'(ready_m), 1);
    @(posedge clk);
  endtask

  // follows cycles 1..100*P+1 after an accept; next command is presented in cycle 1
  task automatic expect_frame(input logic [7:0] op, input logic [15:0] a, input logic [31:0] d,
                              input logic nv, input logic [7:0] nop, input logic [15:0] na,
                              input logic [31:0] nd);
    int p, txd_err, ready_err, done_at;
    p = bpc();
    model(op, a, d);
    txd_err = 0;
    ready_err = 0;
    done_at = 0;
    for (int i = 0; i < 10; i++) rx_b[i] = 8'h00;
    for (int k = 1; k <= 100 * p + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        abort = 1'b0;
        set_valid(nv);
        set_cmd(nop, na, nd);
      end
      if (k <= 100 * p) begin
        int j, pos;
        logic eb;
        j = (k - 1) / p;
        pos = j % 10;
        if (pos == 0)      eb = 1'b0;
        else if (pos == 9) eb = 1'b1;
        else               eb = exp_b[j / 10][pos - 1];
        if (txd_m !== eb) txd_err++;
        if (ready_m !== 1'b0 || busy_m !== 1'b1) ready_err++;
        if ((k - 1) % p == p / 2 && pos >= 1 && pos <= 8) rx_b[j / 10][pos - 1] = txd_m;
      end
      if (done_m === 1'b1 && done_at == 0) done_at = k;
    end
    chk("txd_stream", txd_err, 0);
    chk("busy_ready", ready_err, 0);
    chk("done_latency", done_at, 100 * p + 1);
    chk("done_ready", 32'(ready_m), 1);
    chk("gap_txd", 32'(txd_m), 1);
    for (int i = 0; i < 10; i++) chk("frame_byte", 32'(rx_b[i]), 32'(exp_b[i]));
  endtask

  task automatic one_frame(input logic [7:0] op, input logic [15:0] a, input logic [31:0] d,
                           input logic ab);
    accept(op, a, d, ab);
    expect_frame(op, a, d, 1'b0, 8'h00, 16'h0000, 32'h0);
  endtask

  task automatic rand_frame(input logic ab);
    logic [7:0]  op;
    logic [15:0] a;
    logic [31:0] d;
    op = 8'($urandom);
    a  = 16'($urandom);
    d  = $urandom;
    one_frame(op, a, d, ab);
  endtask

  initial begin
    int p, derr;
    basic_lit = '{8'h5A, 8'hA5, 8'h01, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h81};
    reset_n = 1'b0;
    valid4 = 1'b0;
    valid2 = 1'b0;
    abort = 1'b0;
    set_cmd(8'h00, 16'h0000, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd_m), 1);
    chk("rst_ready", 32'(ready_m), 1);
    chk("rst_busy", 32'(busy_m), 0);
    chk("rst_done", 32'(done_m), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic frame at BAUD_PERIOD=4
    one_frame(8'h01, 16'h1234, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 10; i++) chk("basic_lit", 32'(rx_b[i]), 32'(basic_lit[i]));

    one_frame(8'hFF, 16'h0000, 32'h0, 1'b0);
    chk("csum_ff", 32'(rx_b[9]), 32'h01);
    one_frame(8'h00, 16'h0000, 32'h0, 1'b0);
    chk("csum_zero", 32'(rx_b[9]), 32'h00);
    one_frame(8'h80, 16'h8080, 32'h80808080, 1'b0);
    chk("csum_80", 32'(rx_b[9]), 32'h80);

    // back-to-back with valid held and inputs changed mid-frame
    accept(8'h3C, 16'hBEEF, 32'h01234567, 1'b0);
    expect_frame(8'h3C, 16'hBEEF, 32'h01234567, 1'b1, 8'hC3, 16'h5511, 32'h89ABCDEF);
    expect_frame(8'hC3, 16'h5511, 32'h89ABCDEF, 1'b0, 8'h00, 16'h0000, 32'h0);

    // abort during byte 4, data bit 3
    p = bpc();
    accept(8'h01, 16'h1234, 32'hDEADBEEF, 1'b0);
    for (int k = 1; k <= 44 * p + 2; k++) begin
      @(negedge clk);
      if (k == 1) set_valid(1'b0);
    end
    chk("pre_abort_txd", 32'(txd_m), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_txd", 32'(txd_m), 1);
    chk("abort_ready", 32'(ready_m), 1);
    derr = 0;
    for (int k = 0; k < 12 * p; k++) begin
      if (done_m !== 1'b0 || txd_m !== 1'b1) derr++;
      @(negedge clk);
    end
    chk("abort_quiet", derr, 0);
    rand_frame(1'b0);

    // async reset on the start bit of byte 6
    accept(8'h01, 16'h1234, 32'hDEADBEEF, 1'b0);
    for (int k = 1; k <= 60 * p + 1; k++) begin
      @(negedge clk);
      if (k == 1) set_valid(1'b0);
    end
    chk("pre_reset_txd", 32'(txd_m), 0);
    #1 reset_n = 1'b0;
    #1;
    chk("areset_txd", 32'(txd_m), 1);
    chk("areset_busy", 32'(busy_m), 0);
    chk("areset_done", 32'(done_m), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 32'(ready_m), 1);
    one_frame(8'h01, 16'h1234, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 10; i++) chk("post_reset_lit", 32'(rx_b[i]), 32'(basic_lit[i]));

    // random commands; one accepted with abort high in idle
    rand_frame(1'b1);
    rand_frame(1'b0);
    rand_frame(1'b0);

    // minimum baud period
    cur_sel = 1;
    one_frame(8'h01, 16'h1234, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 10; i++) chk("bp2_lit", 32'(rx_b[i]), 32'(basic_lit[i]));
    rand_frame(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
